// File: rtl/io_event_collector.sv
// Collects single-cycle SoC event pulses, round-robin arbitrates them into
// 8-bit event IDs and queues those IDs for the uDMA event port.
module io_event_collector #(
    parameter int         NB_EVT      = 16,
    parameter logic [7:0] EVT_ID_BASE = 8'd128,
    parameter int         DEPTH       = 4
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_ni,
    input  logic [NB_EVT-1:0]        evt_i,
    output logic                     event_valid_o,
    output logic [7:0]               event_data_o,
    input  logic                     event_ready_i,
    output logic                     lost_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o
);

    localparam int PW = (NB_EVT > 1) ? $clog2(NB_EVT) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [NB_EVT-1:0] pending;
    logic [NB_EVT-1:0] grant_mask;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     rr_next;
    logic [LW-1:0]     level;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        push_id;
    logic              full;
    logic              empty;
    logic              grant;
    logic              pop;
    logic              found;
    logic              lost_q;
    int                idx;

    // Full/empty come from the registered level, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        full  = (level == LW'(DEPTH));
        empty = (level == '0);
        grant = (|pending) && !full;
        pop   = !empty && event_ready_i;
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NB_EVT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NB_EVT) begin
                idx = idx - NB_EVT;
            end
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
        grant_mask = '0;
        if (grant) begin
            grant_mask[winner] = 1'b1;
        end
        rr_next = (winner == PW'(NB_EVT - 1)) ? '0 : winner + PW'(1);
        push_id = EVT_ID_BASE + 8'(winner);
    end

    // A new pulse on the granted source re-arms its pending bit (set wins over clear).
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            pending <= '0;
            rr_ptr  <= '0;
            lost_q  <= 1'b0;
        end else begin
            pending <= (pending & ~grant_mask) | evt_i;
            lost_q  <= |(evt_i & pending & ~grant_mask);
            if (grant) begin
                rr_ptr <= rr_next;
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case ({grant, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (grant) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge sys_clk_i) begin
        if (grant) begin
            mem[wr_ptr] <= push_id;
        end
    end

    assign event_valid_o = !empty;
    assign event_data_o  = empty ? 8'd0 : mem[rd_ptr];
    assign lost_o        = lost_q;
    assign fifo_level_o  = level;

endmodule

// File: tb/tb_io_event_collector.sv
// Directed bench for io_event_collector: latency, round-robin order,
// backpressure, overflow loss, grant/pulse collision and mid-stream reset.
module tb_io_event_collector;

    logic        sys_clk_i;
    logic        sys_rst_ni;
    logic [15:0] evt_i;
    logic        event_valid_o;
    logic [7:0]  event_data_o;
    logic        event_ready_i;
    logic        lost_o;
    logic [2:0]  fifo_level_o;

    int num_checks;
    int num_fail;

    io_event_collector #(
        .NB_EVT      (16),
        .EVT_ID_BASE (8'd128),
        .DEPTH       (4)
    ) dut (
        .sys_clk_i     (sys_clk_i),
        .sys_rst_ni    (sys_rst_ni),
        .evt_i         (evt_i),
        .event_valid_o (event_valid_o),
        .event_data_o  (event_data_o),
        .event_ready_i (event_ready_i),
        .lost_o        (lost_o),
        .fifo_level_o  (fifo_level_o)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_ni    = 1'b0;
        evt_i         = '0;
        event_ready_i = 1'b0;
        tick();
        tick();
        sys_rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        sys_rst_ni    = 1'b0;
        evt_i         = '0;
        event_ready_i = 1'b0;
        tick();
        tick();
        num_checks++;
        if (event_valid_o !== 1'b0) begin
            num_fail++;
            $display("FAIL reset_valid: got %0b expected 0", event_valid_o);
        end
        num_checks++;
        if (event_data_o !== 8'd0) begin
            num_fail++;
            $display("FAIL reset_data: got %0d expected 0", event_data_o);
        end
        num_checks++;
        if (lost_o !== 1'b0) begin
            num_fail++;
            $display("FAIL reset_lost: got %0b expected 0", lost_o);
        end
        num_checks++;
        if (fifo_level_o !== 3'd0) begin
            num_fail++;
            $display("FAIL reset_level: got %0d expected 0", fifo_level_o);
        end
        sys_rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_event();
        do_reset();
        event_ready_i = 1'b1;
        evt_i = 16'h0008;
        tick();
        evt_i = '0;
        num_checks++;
        if (event_valid_o !== 1'b0 || fifo_level_o !== 3'd0) begin
            num_fail++;
            $display("FAIL single_pending: valid %0b level %0d expected 0/0", event_valid_o, fifo_level_o);
        end
        tick();
        num_checks++;
        if (event_valid_o !== 1'b1 || event_data_o !== 8'd131 || fifo_level_o !== 3'd1) begin
            num_fail++;
            $display("FAIL single_valid: valid %0b data %0d level %0d expected 1/131/1",
                     event_valid_o, event_data_o, fifo_level_o);
        end
        num_checks++;
        if (lost_o !== 1'b0) begin
            num_fail++;
            $display("FAIL single_lost: got %0b expected 0", lost_o);
        end
        tick();
        num_checks++;
        if (event_valid_o !== 1'b0 || fifo_level_o !== 3'd0 || event_data_o !== 8'd0) begin
            num_fail++;
            $display("FAIL single_drain: valid %0b level %0d data %0d expected 0/0/0",
                     event_valid_o, fifo_level_o, event_data_o);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_ids [5];
        exp_ids[0] = 8'd128;
        exp_ids[1] = 8'd133;
        exp_ids[2] = 8'd143;
        exp_ids[3] = 8'd128;
        exp_ids[4] = 8'd143;
        do_reset();
        event_ready_i = 1'b1;
        evt_i = 16'h8021;
        tick();
        evt_i = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            num_checks++;
            if (event_valid_o !== 1'b1 || event_data_o !== exp_ids[i]) begin
                num_fail++;
                $display("FAIL rr_first_%0d: valid %0b data %0d expected 1/%0d",
                         i, event_valid_o, event_data_o, exp_ids[i]);
            end
        end
        tick();
        num_checks++;
        if (event_valid_o !== 1'b0) begin
            num_fail++;
            $display("FAIL rr_gap: valid %0b expected 0", event_valid_o);
        end
        // Pointer wrapped to 0 after granting source 15, so source 0 wins again.
        evt_i = 16'h8001;
        tick();
        evt_i = '0;
        for (int i = 3; i < 5; i++) begin
            tick();
            num_checks++;
            if (event_valid_o !== 1'b1 || event_data_o !== exp_ids[i]) begin
                num_fail++;
                $display("FAIL rr_second_%0d: valid %0b data %0d expected 1/%0d",
                         i, event_valid_o, event_data_o, exp_ids[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        event_ready_i = 1'b0;
        evt_i = 16'h007E;
        tick();
        evt_i = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        num_checks++;
        if (fifo_level_o !== 3'd4 || event_valid_o !== 1'b1 || event_data_o !== 8'd129) begin
            num_fail++;
            $display("FAIL bp_full: level %0d valid %0b data %0d expected 4/1/129",
                     fifo_level_o, event_valid_o, event_data_o);
        end
        event_ready_i = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (event_valid_o === 1'b1) begin
                num_checks++;
                if (n > 5 || event_data_o !== 8'(129 + n)) begin
                    num_fail++;
                    $display("FAIL bp_order_%0d: data %0d expected %0d", n, event_data_o, 129 + n);
                end
                n++;
            end
            num_checks++;
            if (lost_o !== 1'b0) begin
                num_fail++;
                $display("FAIL bp_lost: got %0b expected 0", lost_o);
            end
            tick();
            if (i == 0) begin
                num_checks++;
                if (fifo_level_o !== 3'd3 || event_data_o !== 8'd130) begin
                    num_fail++;
                    $display("FAIL bp_first_pop: level %0d data %0d expected 3/130", fifo_level_o, event_data_o);
                end
            end
        end
        num_checks++;
        if (n !== 6) begin
            num_fail++;
            $display("FAIL bp_count: got %0d expected 6", n);
        end
    endtask

    task automatic test_overflow_loss();
        int n;
        int lost_count;
        logic [7:0] exp_ids [5];
        exp_ids[0] = 8'd136;
        exp_ids[1] = 8'd137;
        exp_ids[2] = 8'd138;
        exp_ids[3] = 8'd139;
        exp_ids[4] = 8'd130;
        do_reset();
        event_ready_i = 1'b0;
        evt_i = 16'h0F00;
        tick();
        evt_i = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        lost_count = 0;
        evt_i = 16'h0004;
        tick();
        evt_i = '0;
        if (lost_o === 1'b1) lost_count++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lost_o === 1'b1) lost_count++;
        end
        num_checks++;
        if (lost_count !== 0) begin
            num_fail++;
            $display("FAIL loss_first_pulse: lost pulses %0d expected 0", lost_count);
        end
        evt_i = 16'h0004;
        tick();
        evt_i = '0;
        num_checks++;
        if (lost_o !== 1'b1) begin
            num_fail++;
            $display("FAIL loss_pulse: got %0b expected 1", lost_o);
        end
        tick();
        num_checks++;
        if (lost_o !== 1'b0) begin
            num_fail++;
            $display("FAIL loss_single_cycle: got %0b expected 0", lost_o);
        end
        event_ready_i = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (event_valid_o === 1'b1) begin
                num_checks++;
                if (n > 4 || event_data_o !== exp_ids[n > 4 ? 4 : n]) begin
                    num_fail++;
                    $display("FAIL loss_drain_%0d: data %0d expected %0d", n, event_data_o, exp_ids[n > 4 ? 4 : n]);
                end
                n++;
            end
            tick();
        end
        num_checks++;
        if (n !== 5) begin
            num_fail++;
            $display("FAIL loss_count: got %0d IDs expected 5", n);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        event_ready_i = 1'b1;
        evt_i = 16'h0080;
        tick();
        tick();
        evt_i = '0;
        num_checks++;
        if (event_valid_o !== 1'b1 || event_data_o !== 8'd135 || lost_o !== 1'b0) begin
            num_fail++;
            $display("FAIL b2b_first: valid %0b data %0d lost %0b expected 1/135/0",
                     event_valid_o, event_data_o, lost_o);
        end
        tick();
        num_checks++;
        if (event_valid_o !== 1'b1 || event_data_o !== 8'd135 || lost_o !== 1'b0 || fifo_level_o !== 3'd1) begin
            num_fail++;
            $display("FAIL b2b_second: valid %0b data %0d lost %0b level %0d expected 1/135/0/1",
                     event_valid_o, event_data_o, lost_o, fifo_level_o);
        end
        tick();
        num_checks++;
        if (event_valid_o !== 1'b0 || lost_o !== 1'b0) begin
            num_fail++;
            $display("FAIL b2b_end: valid %0b lost %0b expected 0/0", event_valid_o, lost_o);
        end
    endtask

    task automatic test_reset_midstream();
        int stale;
        do_reset();
        event_ready_i = 1'b0;
        evt_i = 16'h001F;
        tick();
        evt_i = '0;
        tick();
        tick();
        tick();
        num_checks++;
        if (fifo_level_o !== 3'd3) begin
            num_fail++;
            $display("FAIL mid_level: got %0d expected 3", fifo_level_o);
        end
        #2;
        sys_rst_ni = 1'b0;
        #1;
        num_checks++;
        if (event_valid_o !== 1'b0 || fifo_level_o !== 3'd0 || event_data_o !== 8'd0) begin
            num_fail++;
            $display("FAIL mid_async: valid %0b level %0d data %0d expected 0/0/0",
                     event_valid_o, fifo_level_o, event_data_o);
        end
        tick();
        sys_rst_ni    = 1'b1;
        event_ready_i = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (event_valid_o !== 1'b0) stale++;
        end
        num_checks++;
        if (stale !== 0) begin
            num_fail++;
            $display("FAIL mid_stale: %0d cycles valid expected 0", stale);
        end
    endtask

    initial begin
        num_checks    = 0;
        num_fail      = 0;
        sys_rst_ni    = 1'b0;
        evt_i         = '0;
        event_ready_i = 1'b0;
        test_reset();
        test_single_event();
        test_round_robin();
        test_backpressure();
        test_overflow_loss();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
